// File: rtl/mux_arb_stream.sv
// N-input round-robin stream mux with a single registered valid/ready output stage.
// Define MUX_ARB_PKT_LOCK_EN to add in_last/out_last and hold the grant until a packet ends.
module mux_arb_stream #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    localparam int SEL_W = $clog2(N)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N-1:0]       in_valid,
    input  logic [N*WIDTH-1:0] in_data,
    output logic [N-1:0]       in_ready,
`ifdef MUX_ARB_PKT_LOCK_EN
    input  logic [N-1:0]       in_last,
    output logic               out_last,
`endif
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [SEL_W-1:0]   out_sel,
    input  logic               out_ready
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0] out_sel_q, out_sel_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
`ifdef MUX_ARB_PKT_LOCK_EN
    logic             locked_q, locked_d;
    logic [SEL_W-1:0] lock_ch_q, lock_ch_d;
    logic             out_last_q, out_last_d;
`endif

    logic             load;
    logic             found;
    logic             accept;
    logic [SEL_W-1:0] grant_ch;
    logic [SEL_W-1:0] cand;
    logic [SEL_W-1:0] next_ptr;
    logic [WIDTH-1:0] grant_data;
    int               idx;

    assign load = !out_valid_q || out_ready;

    // First valid channel scanning upward from ptr, wrapping at N (also for non-power-of-2 N).
    always_comb begin
        found    = 1'b0;
        grant_ch = '0;
        idx      = 0;
        cand     = '0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N) idx = idx - N;
            cand = SEL_W'(idx);
            if (!found && in_valid[cand]) begin
                found    = 1'b1;
                grant_ch = cand;
            end
        end
`ifdef MUX_ARB_PKT_LOCK_EN
        if (locked_q) begin
            found    = in_valid[lock_ch_q];
            grant_ch = lock_ch_q;
        end
`endif
    end

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_ch == SEL_W'(i)) grant_data = in_data[i*WIDTH +: WIDTH];
        end
    end

    assign accept   = load && found && !reset;
    assign next_ptr = (grant_ch == SEL_W'(N-1)) ? '0 : grant_ch + SEL_W'(1);

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < N; i++) begin
            in_ready[i] = accept && (grant_ch == SEL_W'(i));
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        ptr_d       = ptr_q;
`ifdef MUX_ARB_PKT_LOCK_EN
        locked_d    = locked_q;
        lock_ch_d   = lock_ch_q;
        out_last_d  = out_last_q;
`endif
        if (load) begin
            out_valid_d = found;
            if (found) begin
                out_data_d = grant_data;
                out_sel_d  = grant_ch;
`ifdef MUX_ARB_PKT_LOCK_EN
                out_last_d = in_last[grant_ch];
                locked_d   = !in_last[grant_ch];
                lock_ch_d  = grant_ch;
                // Pointer moves only once the packet closes.
                if (in_last[grant_ch]) ptr_d = next_ptr;
`else
                ptr_d      = next_ptr;
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            ptr_q       <= '0;
`ifdef MUX_ARB_PKT_LOCK_EN
            locked_q    <= 1'b0;
            lock_ch_q   <= '0;
            out_last_q  <= 1'b0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
`ifdef MUX_ARB_PKT_LOCK_EN
            locked_q    <= locked_d;
            lock_ch_q   <= lock_ch_d;
            out_last_q  <= out_last_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
`ifdef MUX_ARB_PKT_LOCK_EN
    assign out_last  = out_last_q;
`endif

endmodule

// File: tb/tb_mux_arb_stream.sv
// Directed bench for mux_arb_stream: a 4-channel and a 3-channel instance, 8-bit data.
module tb_mux_arb_stream;

    logic        clk = 1'b0;
    logic        reset;

    logic [3:0]  in_valid4;
    logic [31:0] in_data4;
    logic [3:0]  in_ready4;
    logic        out_valid4;
    logic [7:0]  out_data4;
    logic [1:0]  out_sel4;
    logic        out_ready4;

    logic [2:0]  in_valid3;
    logic [23:0] in_data3;
    logic [2:0]  in_ready3;
    logic        out_valid3;
    logic [7:0]  out_data3;
    logic [1:0]  out_sel3;
    logic        out_ready3;

`ifdef MUX_ARB_PKT_LOCK_EN
    logic [3:0]  in_last4;
    logic        out_last4;
    logic [2:0]  in_last3;
    logic        out_last3;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux_arb_stream #(.WIDTH(8), .N(4)) dut4 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid4), .in_data(in_data4), .in_ready(in_ready4),
`ifdef MUX_ARB_PKT_LOCK_EN
        .in_last(in_last4), .out_last(out_last4),
`endif
        .out_valid(out_valid4), .out_data(out_data4), .out_sel(out_sel4),
        .out_ready(out_ready4)
    );

    mux_arb_stream #(.WIDTH(8), .N(3)) dut3 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid3), .in_data(in_data3), .in_ready(in_ready3),
`ifdef MUX_ARB_PKT_LOCK_EN
        .in_last(in_last3), .out_last(out_last3),
`endif
        .out_valid(out_valid3), .out_data(out_data3), .out_sel(out_sel3),
        .out_ready(out_ready3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        in_valid4  = 4'hF;
        in_data4   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        out_ready4 = 1'b0;
        in_valid3  = 3'b000;
        in_data3   = {8'hC2, 8'hC1, 8'hC0};
        out_ready3 = 1'b0;
`ifdef MUX_ARB_PKT_LOCK_EN
        in_last4   = 4'hF;
        in_last3   = 3'b111;
`endif
        #1;
        check("rst_in_ready", 32'(in_ready4), 32'h0);
        tick();
        tick();
        check("rst_out_valid", 32'(out_valid4), 32'h0);
        check("rst_out_data", 32'(out_data4), 32'h0);
        check("rst_out_sel", 32'(out_sel4), 32'h0);

        // Round-robin with all four channels valid
        reset      = 1'b0;
        out_ready4 = 1'b1;
        #1;
        check("rr_first_ready", 32'(in_ready4), 32'h1);
        tick();
        check("rr_sel0", 32'(out_sel4), 32'h0);
        check("rr_data0", 32'(out_data4), 32'hA0);
        check("rr_valid0", 32'(out_valid4), 32'h1);
        check("rr_ready_next", 32'(in_ready4), 32'h2);
        for (int k = 1; k <= 4; k++) begin
            tick();
            check("rr_sel", 32'(out_sel4), 32'(k % 4));
            check("rr_data", 32'(out_data4), 32'(8'hA0 + (k % 4)));
        end

        // Backpressure: held beat (ch0, A0) must not move; ptr now 1
        out_ready4 = 1'b0;
        in_data4   = {8'hB3, 8'hB2, 8'hB1, 8'hB0};
        #1;
        check("bp_in_ready", 32'(in_ready4), 32'h0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp_data", 32'(out_data4), 32'hA0);
            check("bp_sel", 32'(out_sel4), 32'h0);
            check("bp_valid", 32'(out_valid4), 32'h1);
            check("bp_in_ready_hold", 32'(in_ready4), 32'h0);
        end
        out_ready4 = 1'b1;
        #1;
        check("bp_release_ready", 32'(in_ready4), 32'h2);
        tick();
        check("bp_drain_fill_sel", 32'(out_sel4), 32'h1);
        check("bp_drain_fill_data", 32'(out_data4), 32'hB1);

        // Idle drain: valid drops, data holds
        in_valid4 = 4'h0;
        tick();
        check("idle_valid", 32'(out_valid4), 32'h0);
        check("idle_data", 32'(out_data4), 32'hB1);
        check("idle_in_ready", 32'(in_ready4), 32'h0);

        // Async reset between edges; ptr was 2
        in_valid4 = 4'hF;
        tick();
        check("pre_rst_sel", 32'(out_sel4), 32'h2);
        check("pre_rst_data", 32'(out_data4), 32'hB2);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_valid", 32'(out_valid4), 32'h0);
        check("async_rst_data", 32'(out_data4), 32'h0);
        check("async_rst_in_ready", 32'(in_ready4), 32'h0);
        #1;
        reset = 1'b0;
        #1;
        check("post_rst_ready", 32'(in_ready4), 32'h1);
        tick();
        check("post_rst_sel", 32'(out_sel4), 32'h0);
        check("post_rst_data", 32'(out_data4), 32'hB0);
        in_valid4 = 4'h0;

        // N=3 wrap: only ch2, then ch0 and ch2
        out_ready3 = 1'b1;
        in_valid3  = 3'b100;
        #1;
        check("n3_ready_ch2", 32'(in_ready3), 32'h4);
        tick();
        check("n3_sel2", 32'(out_sel3), 32'h2);
        check("n3_data2", 32'(out_data3), 32'hC2);
        in_valid3 = 3'b101;
        #1;
        check("n3_wrap_ready", 32'(in_ready3), 32'h1);
        tick();
        check("n3_sel0", 32'(out_sel3), 32'h0);
        check("n3_data0", 32'(out_data3), 32'hC0);
        check("n3_next_ready", 32'(in_ready3), 32'h4);
        in_valid3 = 3'b000;

`ifdef MUX_ARB_PKT_LOCK_EN
        // Packet lock: ptr to 1, then ch1 sends a 3-beat packet against ch0/ch2
        tick();
        reset = 1'b1;
        #1;
        reset = 1'b0;
        in_valid4 = 4'b0001;
        in_last4  = 4'hF;
        tick();
        check("lk_pre_sel", 32'(out_sel4), 32'h0);
        in_valid4 = 4'b0111;
        in_last4  = 4'h0;
        #1;
        check("lk_ready_b0", 32'(in_ready4), 32'h2);
        tick();
        check("lk_sel_b0", 32'(out_sel4), 32'h1);
        check("lk_last_b0", 32'(out_last4), 32'h0);
        #1;
        check("lk_ready_b1", 32'(in_ready4), 32'h2);
        tick();
        check("lk_sel_b1", 32'(out_sel4), 32'h1);
        in_last4 = 4'b0010;
        #1;
        check("lk_ready_b2", 32'(in_ready4), 32'h2);
        tick();
        check("lk_sel_b2", 32'(out_sel4), 32'h1);
        check("lk_last_b2", 32'(out_last4), 32'h1);
        in_valid4 = 4'b0101;
        in_last4  = 4'hF;
        #1;
        check("lk_ready_ch2", 32'(in_ready4), 32'h4);
        tick();
        check("lk_sel_ch2", 32'(out_sel4), 32'h2);
        #1;
        check("lk_ready_ch0", 32'(in_ready4), 32'h1);
        tick();
        check("lk_sel_ch0", 32'(out_sel4), 32'h0);
        in_valid4 = 4'h0;
`endif

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_arb_stream.md
# mux_arb_stream

Parametrised N-input stream multiplexer with round-robin arbitration and a registered, valid/ready-handshaked output. It generalises the core's combinational select muxes to N channels of WIDTH bits, where the select is generated internally by a fair arbiter rather than driven by control logic. Its intended use is merging requesters, such as instruction fetch, data port and debug, onto a single memory or bus port.

## Interface
- `WIDTH`, 32, data width per channel (≥1)
- `N`, 4, number of input channels (≥2); `SEL_W = $clog2(N)` is derived as a localparam
- `clk` input 1: single clock, rising edge
- `reset` input 1: asynchronous, active-high reset
- `in_valid` input N: per-channel beat valid
- `in_data` input N*WIDTH: channel i occupies bits `[i*WIDTH +: WIDTH]`
- `in_ready` output N: per-channel accept; one-hot or zero
- `in_last` input N: end-of-packet marker; present only with `MUX_ARB_PKT_LOCK_EN`
- `out_valid` output 1: output register holds a beat
- `out_data` output WIDTH: registered data
- `out_sel` output SEL_W: source channel of the held beat
- `out_last` output 1: registered `in_last` of the held beat; present only with `MUX_ARB_PKT_LOCK_EN`
- `out_ready` input 1: downstream accept

## Operation
- Single output register stage with no skid buffer.
- `load = !out_valid || out_ready`.
- Arbiter: round-robin pointer `ptr`. The granted channel is the first i with `in_valid[i]`, scanning `ptr, ptr+1, …, N-1, 0, …` (mod N).
- `in_ready[i] = load && grant[i]`. This path is combinational from `out_ready` and `in_valid`. `in_ready` never depends on `in_ready`.
- On a load with a grant g:
  - `out_data <= in_data[g]`, `out_sel <= g`, `out_valid <= 1`
  - `ptr <= (g+1) mod N`, wrapping N-1 → 0. This also holds for non-power-of-2 N.
- On a load with no `in_valid`: `out_valid <= 0`. `out_data`, `out_sel` and `ptr` hold.
- While `out_valid && !out_ready`, all outputs and `ptr` hold and every `in_ready` is 0.
- Simultaneous drain and fill is allowed: a full register with `out_ready=1` accepts a new beat in the same cycle, giving a throughput of 1 beat per cycle.
- Fairness: a continuously valid channel is granted within N accepted beats.

## Timing
- Latency: a beat accepted at edge k appears on `out_*` after edge k and is held until it is consumed.
- Reset values: `out_valid=0`, `out_data=0`, `out_sel=0`, `ptr=0`, `locked=0`. After reset, channel 0 has top priority.
- `in_ready` is all zero while `reset` is asserted.
- Reset asserted mid-operation: the held beat is discarded and any packet lock is dropped. No partial state survives.
- `in_valid` may drop without a handshake. The block tolerates this and does not require the AXI valid-stickiness rule.

## Configuration
- Macro: `MUX_ARB_PKT_LOCK_EN`.
- Defined (packet lock):
  - Adds the `in_last` and `out_last` ports.
  - When channel g is accepted with `in_last[g]=0`, set `locked=1` and `lock_ch=g`.
  - While locked, only `lock_ch` can be granted, even if other channels are valid. If `lock_ch` is not valid, no grant is made.
  - `ptr` advances only on a beat accepted with `in_last=1`. That beat also clears `locked`.
  - A single-beat packet (`in_last=1` on its first beat) behaves exactly as the non-lock mode.
- Undefined: no last ports and no lock state. Every beat is arbitrated independently.

## Test plan
- Reset, then `in_valid=4'b1111` and `out_ready=1` held: grants go 0, 1, 2, 3, 0, …, one per cycle. `out_sel` sequence is 0, 1, 2, 3, 0. Data is unchanged through the block.
- Backpressure: `out_ready=0` with the register full. `in_ready=0`, and `out_data` stays stable for 5 cycles. On `out_ready=1`, the held beat drains and the next beat loads on the same edge.
- Wrap with N=3 and only channel 2 valid: `out_sel=2` and `ptr` wraps to 0. Then channels 0 and 2 are valid: grant goes to channel 0.
- Idle drain: one beat held, `out_ready=1`, no `in_valid`. The next cycle has `out_valid=0` and `out_data` holding its old value.
- Asynchronous reset pulse mid-stream, between clock edges: `out_valid` goes to 0 immediately and `in_ready=0`. After release, channel 0 is granted first.
- With `MUX_ARB_PKT_LOCK_EN`: channel 1 sends 3 beats (last on the 3rd) while channels 0 and 2 are valid. Result: three consecutive beats with `out_sel=1`, then channel 2, then channel 0.
